egress_port_drain: RTL and testbench
====================================

# egress_port_drain

Per-port drain stage directly downstream of the switch's upstream (output) interface. It watches `valid_out`, pulses `data_rd` to consume each word, and checks `addr_out` against a configured port address. Matching words go into a local FIFO that a sink consumes over a valid/ready handshake; non-matching words are consumed, discarded and counted. One instance is placed per switch output port.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  single clock; everything samples on the rising edge.
- `rst_b`  in  1  reset, synchronous, active-high.
- `valid_out`  in  1  switch has a word on `addr_out`/`data_out`.
- `addr_out`  in  8  destination address of the presented word.
- `data_out`  in  8  payload of the presented word.
- `data_rd`  out  1  read strobe to the switch; the word is consumed on an edge where `data_rd`=1.
- `my_addr`  in  8  address this port accepts; quasi-static.
- `sink_valid`  out  1  FIFO head is valid.
- `sink_addr`  out  8  FIFO head address.
- `sink_data`  out  8  FIFO head data.
- `sink_ready`  in  1  sink accepts the head.
- `fifo_count`  out  $clog2(DEPTH+1)  current occupancy.
- `pkt_cnt`  out  CNT_W  count of words accepted into the FIFO.
- `drop_cnt`  out  CNT_W  count of consumed words whose address did not match.

## Operation
- The read FSM has three states: IDLE, READ, GAP.
  - IDLE → READ when `valid_out`=1 and `fifo_count`<DEPTH. Otherwise stay in IDLE.
  - READ → GAP unconditionally. In READ, `data_rd`=1. Decode `data_rd` from the state register only; no combinational path from any input.
  - GAP → IDLE unconditionally, with `data_rd`=0. GAP gives the switch one cycle to retire or update `valid_out`.
- On the READ edge, capture `addr_out`/`data_out`:
  - If `addr_out`==`my_addr`, push to the FIFO and increment `pkt_cnt`.
  - Otherwise discard the word and increment `drop_cnt`.
- `my_addr` is compared only in READ. A change to `my_addr` affects the next capture only.
- FIFO is first-word-fall-through:
  - `sink_valid` = (`fifo_count`≠0).
  - Head data is presented continuously.
  - Pop on an edge where `sink_valid`&&`sink_ready`.
- Only one read is ever in flight and pushes occur only from READ. The IDLE full-check is therefore exact, and the FIFO never overflows.
- Simultaneous push and pop: `fifo_count` unchanged, and ordering is preserved.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is tracked by the separate count.
- Counters saturate at all-ones and do not wrap.
- `valid_out` dropping while in READ is a protocol error by the switch. The block still captures on that edge, and no extra recovery is required.

## Timing
- Reset, sampled at the edge when `rst_b`=1:
  - FSM goes to IDLE, FIFO pointers and count go to 0.
  - `data_rd`=0, `sink_valid`=0, `sink_addr`=0, `sink_data`=0, `fifo_count`=0, `pkt_cnt`=0, `drop_cnt`=0.
- Reset asserted while in READ: the in-flight capture is discarded, and `data_rd` is 0 in the following cycle.
- Latency: `valid_out` high in cycle 0 with the FIFO not full gives:
  - `data_rd`=1 in cycle 1;
  - `sink_valid`=1 and head = that word in cycle 2, for a matching address.
- Throughput: at most one word per 3 cycles (IDLE, READ, GAP).
- Full: with `fifo_count`=DEPTH, the FSM holds IDLE and `data_rd` stays 0. The read resumes in the cycle after a pop makes room.
- `sink_*` outputs change only on edges. The head advances one cycle after a pop.

## Structure
- Package `egress_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, READ, GAP} drain_state_t`;
  - `localparam ADDR_W=8`, `DATA_W=8`;
  - the packed struct `drain_word_t {addr, data}` used as the FIFO entry.
- One sub-module, `sync_fifo_fwft`, parameterised by DEPTH and entry type. It is instantiated once and holds storage, pointers and count.
- The top level holds the FSM, the address compare and the saturating counters.

## Test plan
- **Reset values:** assert `rst_b` for 2 cycles with `valid_out`=1 → all outputs 0, `data_rd` never asserted during reset.
- **Single match:** `my_addr`=8'h05; switch presents {05, A3} → `data_rd` pulses 1 cycle, two cycles later `sink_valid`=1 with `sink_addr`=05 and `sink_data`=A3, `pkt_cnt`=1.
- **Mismatch drop:** `my_addr`=05; present {07, 11} → `data_rd` pulses, `sink_valid` stays 0, `drop_cnt`=1, `pkt_cnt`=0.
- **Full backpressure:** `sink_ready`=0; stream 10 matching words with DEPTH=8 → exactly 8 `data_rd` pulses, `fifo_count`=8. Raise `sink_ready` → remaining 2 are read and all 10 emerge in order.
- **Simultaneous push/pop:** hold `sink_ready`=1 and stream matching words → every push edge that coincides with a pop leaves `fifo_count` unchanged, with no loss or reordering.
- **Saturation and reset mid-READ:**
  - With CNT_W=4, drop 20 words → `drop_cnt`=4'hF.
  - Assert reset in a READ cycle → that word does not appear at the sink and the counters clear.

Source files
------------

// File: rtl/egress_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | egress_pkg : shared types and widths for the egress port drain             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package egress_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    GAP  = 2'd2
  } drain_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } drain_word_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo_fwft : first-word-fall-through FIFO, head masked to 0 when empty |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sync_fifo_fwft #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  T                             i_data,
  input  logic                         i_pop,
  output T                             o_head,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int COUNT_W = $clog2(DEPTH+1);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam logic [COUNT_W-1:0] c_full = COUNT_W'(DEPTH);

  T                   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [COUNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push && (r_count != c_full);
  assign w_do_pop  = i_pop  && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset, so the head is masked to keep it clean while empty.
  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/egress_port_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | egress_port_drain : reads switch words, keeps matching ones in a FIFO      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module egress_port_drain
  import egress_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         valid_out,
  input  logic [ADDR_W-1:0]            addr_out,
  input  logic [DATA_W-1:0]            data_out,
  output logic                         data_rd,
  input  logic [ADDR_W-1:0]            my_addr,
  output logic                         sink_valid,
  output logic [ADDR_W-1:0]            sink_addr,
  output logic [DATA_W-1:0]            sink_data,
  input  logic                         sink_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic [CNT_W-1:0]             pkt_cnt,
  output logic [CNT_W-1:0]             drop_cnt
);

  localparam int FCNT_W = $clog2(DEPTH+1);
  localparam logic [FCNT_W-1:0] c_full    = FCNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  c_cnt_max = '1;

  drain_state_t r_state;
  drain_state_t w_state_nxt;

  logic        w_match;
  logic        w_push;
  logic        w_drop;
  logic        w_pop;
  drain_word_t w_wr_word;
  drain_word_t w_head;

  logic [CNT_W-1:0] r_pkt_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Only one read is ever outstanding, so the registered count is an exact full check.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (valid_out && (fifo_count != c_full)) w_state_nxt = READ;
      READ:    w_state_nxt = GAP;
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign data_rd   = (r_state == READ);
  assign w_match   = (addr_out == my_addr);
  assign w_push    = data_rd && w_match;
  assign w_drop    = data_rd && !w_match;
  assign w_pop     = sink_valid && sink_ready;
  assign w_wr_word = '{addr: addr_out, data: data_out};

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push && (r_pkt_cnt != c_cnt_max))  r_pkt_cnt  <= r_pkt_cnt + 1'b1;
      if (w_drop && (r_drop_cnt != c_cnt_max)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .T     (drain_word_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst_b),
    .i_push  (w_push),
    .i_data  (w_wr_word),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_valid (sink_valid),
    .o_count (fifo_count)
  );

  assign sink_addr = w_head.addr;
  assign sink_data = w_head.data;
  assign pkt_cnt   = r_pkt_cnt;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_egress_port_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_egress_port_drain : directed and random checks against a queue model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_egress_port_drain;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int FCW   = $clog2(DEPTH+1);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             valid_out;
  logic [7:0]       addr_out;
  logic [7:0]       data_out;
  logic             data_rd;
  logic [7:0]       my_addr;
  logic             sink_valid;
  logic [7:0]       sink_addr;
  logic [7:0]       sink_data;
  logic             sink_ready;
  logic [FCW-1:0]   fifo_count;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] drop_cnt;

  always #5 clk = ~clk;

  egress_port_drain #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .valid_out  (valid_out),
    .addr_out   (addr_out),
    .data_out   (data_out),
    .data_rd    (data_rd),
    .my_addr    (my_addr),
    .sink_valid (sink_valid),
    .sink_addr  (sink_addr),
    .sink_data  (sink_data),
    .sink_ready (sink_ready),
    .fifo_count (fifo_count),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } word_t;

  word_t src_q[$];
  word_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    m_pkt   = 0;
  int    m_drop  = 0;
  int    rd_pulses = 0;
  int    pp_events = 0;
  int    ready_mode = 0;
  bit    obs_rd = 0;
  bit    obs_sv = 0;
  bit    rst_on_rd = 0;
  bit    rst_hit = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    valid_out = (src_q.size() != 0);
    addr_out  = valid_out ? src_q[0].a : 8'h00;
    data_out  = valid_out ? src_q[0].d : 8'h00;
    case (ready_mode)
      0:       sink_ready = 1'b0;
      1:       sink_ready = 1'b1;
      default: sink_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock: predict the coming edge from pre-edge inputs, then check after it.
  task automatic cycle();
    bit    rst_now, consume, pop, pp;
    int    pp_before;
    word_t w;
    consume = (data_rd === 1'b1);
    if (rst_on_rd && consume) begin
      rst_b     = 1'b1;
      rst_on_rd = 1'b0;
      rst_hit   = 1'b1;
    end
    rst_now   = rst_b;
    pop       = (exp_q.size() != 0) && sink_ready;
    pp        = 1'b0;
    pp_before = exp_q.size();
    if (consume) rd_pulses++;
    if (consume && src_q.size() == 0) chk("rd_without_word", data_rd, 1'b0);
    if (rst_now) begin
      exp_q.delete();
      m_pkt  = 0;
      m_drop = 0;
      if (consume && src_q.size() != 0) void'(src_q.pop_front());
    end else begin
      if (consume && src_q.size() != 0) begin
        w = src_q.pop_front();
        if (w.a == my_addr) begin
          pp = pop;
          exp_q.push_back(w);
          if (m_pkt < CMAX) m_pkt++;
        end else begin
          if (m_drop < CMAX) m_drop++;
        end
      end
      if (pop) void'(exp_q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    if (rst_now) begin
      chk("rst_data_rd", data_rd, 1'b0);
      chk("rst_sink_addr", sink_addr, 8'h00);
      chk("rst_sink_data", sink_data, 8'h00);
    end
    if (pp) begin
      pp_events++;
      chk("pushpop_hold", fifo_count, pp_before);
    end
    if (data_rd === 1'b1) begin
      chk("rd_spacing", obs_rd, 1'b0);
      chk("rd_room", exp_q.size() <= DEPTH - 1, 1'b1);
    end
    chk("fifo_count", fifo_count, exp_q.size());
    chk("sink_valid", sink_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("sink_addr", sink_addr, exp_q[0].a);
      chk("sink_data", sink_data, exp_q[0].d);
    end
    chk("pkt_cnt", pkt_cnt, m_pkt);
    chk("drop_cnt", drop_cnt, m_drop);
    obs_rd = data_rd;
    obs_sv = sink_valid;
    drive();
  endtask

  task automatic reset_dut();
    rst_b = 1'b1;
    cycle();
    cycle();
    rst_b = 1'b0;
  endtask

  initial begin
    rst_b      = 1'b1;
    my_addr    = 8'h05;
    ready_mode = 0;
    src_q.delete();
    drive();

    // Reset held two cycles with a word already presented
    src_q.push_back('{8'h05, 8'hA3});
    drive();
    cycle();
    cycle();
    rst_b = 1'b0;

    // Single match: read strobe next cycle, head the cycle after
    cycle();
    chk("single_rd", obs_rd, 1'b1);
    chk("single_sv_early", obs_sv, 1'b0);
    cycle();
    chk("single_rd_off", obs_rd, 1'b0);
    chk("single_sv", obs_sv, 1'b1);
    chk("single_pkt", pkt_cnt, 1);

    // Mismatch is consumed and counted, never reaches the sink
    reset_dut();
    src_q.push_back('{8'h07, 8'h11});
    drive();
    cycle();
    chk("drop_rd", obs_rd, 1'b1);
    repeat (3) cycle();
    chk("drop_sv", sink_valid, 1'b0);
    chk("drop_cnt_one", drop_cnt, 1);
    chk("drop_pkt_zero", pkt_cnt, 0);

    // Full backpressure then release
    reset_dut();
    rd_pulses = 0;
    for (int i = 0; i < 10; i++) src_q.push_back('{8'h05, 8'(8'h10 + i)});
    drive();
    repeat (40) cycle();
    chk("full_rd_pulses", rd_pulses, 8);
    chk("full_count", fifo_count, DEPTH);
    chk("full_no_rd", obs_rd, 1'b0);
    ready_mode = 1;
    repeat (40) cycle();
    chk("full_rd_total", rd_pulses, 10);
    chk("full_drained", fifo_count, 0);
    chk("full_pkt", pkt_cnt, 10);

    // Backlog plus streaming so pushes land on pop edges
    reset_dut();
    ready_mode = 0;
    pp_events  = 0;
    for (int i = 0; i < 3; i++) src_q.push_back('{8'h05, 8'(8'h40 + i)});
    drive();
    repeat (12) cycle();
    for (int i = 0; i < 6; i++) src_q.push_back('{8'h05, 8'(8'h50 + i)});
    ready_mode = 1;
    drive();
    repeat (30) cycle();
    chk("pp_seen", pp_events > 0, 1'b1);
    chk("pp_drained", fifo_count, 0);

    // Drop counter saturation
    reset_dut();
    for (int i = 0; i < 20; i++) src_q.push_back('{8'h05 ^ 8'($urandom_range(1, 255)), 8'(i)});
    drive();
    repeat (80) cycle();
    chk("sat_drop", drop_cnt, 4'hF);
    chk("sat_pkt", pkt_cnt, 0);

    // Reset landing on a READ edge discards that word
    reset_dut();
    ready_mode = 0;
    rd_pulses  = 0;
    src_q.push_back('{8'h05, 8'hC1});
    src_q.push_back('{8'h05, 8'hC2});
    drive();
    for (int k = 0; k < 10 && rd_pulses < 1; k++) cycle();
    repeat (2) cycle();
    chk("mid_pre_pkt", pkt_cnt, 1);
    rst_hit   = 1'b0;
    rst_on_rd = 1'b1;
    for (int k = 0; k < 10 && !rst_hit; k++) cycle();
    chk("mid_rst_found", rst_hit, 1'b1);
    rst_on_rd = 1'b0;
    cycle();
    rst_b = 1'b0;
    repeat (4) cycle();
    chk("mid_sv", sink_valid, 1'b0);
    chk("mid_pkt", pkt_cnt, 0);
    chk("mid_drop", drop_cnt, 0);

    // Random traffic, random sink readiness, an address change midway
    reset_dut();
    my_addr    = 8'h3C;
    ready_mode = 2;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 1) == 1) src_q.push_back('{8'h3C, 8'($urandom)});
      else src_q.push_back('{8'($urandom_range(0, 1) ? 8'h9A : 8'h3C ^ 8'($urandom_range(1, 255))), 8'($urandom)});
    end
    drive();
    for (int k = 0; k < 3000 && (src_q.size() != 0 || exp_q.size() != 0); k++) begin
      if (k == 200) my_addr = 8'h9A;
      cycle();
    end
    ready_mode = 1;
    repeat (4) cycle();
    chk("rand_drained", fifo_count, 0);
    chk("rand_src_empty", valid_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
